// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and mul/div mode types for the iterative ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9,
    OP_MOD = 4'd10
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_MOD = 2'd2
  } md_mode_t;

endpackage

// File: rtl/alu_seq_iter_muldiv.sv
// rtl/alu_seq_iter_muldiv.sv - shift-add multiplier / restoring divider, one bit per step
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               last_i,
  input  md_mode_t           mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               carry_o
);

  md_mode_t             mode_q, mode_c;
  logic [WIDTH-1:0]     x_q, x_c;
  logic [2*WIDTH-1:0]   p_q, p_c, p_d;
  logic [WIDTH:0]       sum, t;
  logic [WIDTH-1:0]     lo, diff;

  // The load cycle already performs the first iteration on the freshly captured operands.
  always_comb begin
    mode_c = load_i ? mode_i : mode_q;
    x_c    = load_i ? ((mode_i == MD_MUL) ? a_i : b_i) : x_q;
    p_c    = load_i ? {{WIDTH{1'b0}}, ((mode_i == MD_MUL) ? b_i : a_i)} : p_q;
    sum    = {1'b0, p_c[2*WIDTH-1:WIDTH]} + (p_c[0] ? {1'b0, x_c} : {(WIDTH+1){1'b0}});
    t      = p_c[2*WIDTH-1:WIDTH-1];
    lo     = {p_c[WIDTH-2:0], 1'b0};
    diff   = t[WIDTH-1:0] - x_c;
    p_d    = p_c;
    if (mode_c == MD_MUL) begin
      p_d = {sum, p_c[WIDTH-1:1]};
    end else if (t >= {1'b0, x_c}) begin
      p_d = {diff, lo[WIDTH-1:1], 1'b1};
    end else begin
      p_d = {t[WIDTH-1:0], lo};
    end
  end

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    case (mode_c)
      MD_MUL: begin
        res_o   = p_d;
        carry_o = |p_d[2*WIDTH-1:WIDTH];
      end
      MD_DIV:  res_o = {{WIDTH{1'b0}}, p_d[WIDTH-1:0]};
      default: res_o = {{WIDTH{1'b0}}, p_d[2*WIDTH-1:WIDTH]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MD_MUL;
      x_q    <= '0;
      p_q    <= '0;
    end else if (last_i) begin
      x_q    <= '0;
      p_q    <= '0;
    end else if (load_i || step_i) begin
      mode_q <= mode_c;
      x_q    <= x_c;
      p_q    <= p_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - iterative ALU feeding the flag register: one-cycle logic ops, WIDTH-cycle mul/div/mod
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               carry
);

  localparam int M  = WIDTH - 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d, ovf_q, ovf_d, carry_q, carry_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               is_iter, md_load, md_step, md_last, last_iter;
  md_mode_t           md_mode;
  logic [2*WIDTH-1:0] md_res, sc_res, sc_wide;
  logic               md_carry, sc_carry, sc_ovf, narrow;
  logic [WIDTH-1:0]   v;

  assign is_iter   = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
  assign md_mode   = (op == OP_MUL) ? MD_MUL : ((op == OP_DIV) ? MD_DIV : MD_MOD);
  assign last_iter = (state_q == RUN) && (cnt_q == CW'(1));

  always_comb begin
    v        = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    narrow   = 1'b1;
    sc_wide  = '0;
    case (op)
      OP_ADD: begin
        {sc_carry, v} = {1'b0, a} + {1'b0, b};
        sc_ovf        = (a[M] == b[M]) && (v[M] != a[M]);
      end
      OP_SUB: begin
        {sc_carry, v} = {1'b0, a} - {1'b0, b};
        sc_ovf        = (a[M] != b[M]) && (v[M] != a[M]);
      end
      OP_AND: v = a & b;
      OP_OR:  v = a | b;
      OP_XOR: v = a ^ b;
      OP_NOT: v = ~a;
      OP_SHL: begin
        v        = {a[M-1:0], 1'b0};
        sc_carry = a[M];
      end
      OP_SHR: begin
        v        = {1'b0, a[M:1]};
        sc_carry = a[0];
      end
      // Only reached with b==0; nonzero divisors take the iterative path.
      OP_DIV: begin
        narrow  = 1'b0;
        sc_wide = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        sc_ovf  = 1'b1;
      end
      OP_MOD: begin
        narrow  = 1'b0;
        sc_wide = {{WIDTH{1'b0}}, a};
        sc_ovf  = 1'b1;
      end
      default: narrow = 1'b0;
    endcase
    sc_res = narrow ? {{WIDTH{v[M]}}, v} : sc_wide;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && is_iter) state_d = RUN;
      RUN:     if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    md_load  = 1'b0;
    md_step  = 1'b0;
    md_last  = 1'b0;
    if (state_q == IDLE) begin
      if (start && is_iter) begin
        md_load = 1'b1;
        cnt_d   = CW'(WIDTH - 1);
      end else if (start) begin
        done_d   = 1'b1;
        result_d = sc_res;
        ovf_d    = sc_ovf;
        carry_d  = sc_carry;
      end
    end else begin
      md_step = 1'b1;
      cnt_d   = cnt_q - CW'(1);
      if (last_iter) begin
        md_last  = 1'b1;
        done_d   = 1'b1;
        result_d = md_res;
        ovf_d    = 1'b0;
        carry_d  = md_carry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
    end
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .load_i  (md_load),
    .step_i  (md_step),
    .last_i  (md_last),
    .mode_i  (md_mode),
    .a_i     (a),
    .b_i     (b),
    .res_o   (md_res),
    .carry_o (md_carry)
  );

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with an arithmetic reference model
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        busy, done, overflow, carry;
  logic [15:0] result;
  int          checks = 0;
  int          failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sext8(input int x);
    return (x >= 128) ? 16'(x + 32'hFF00) : 16'(x);
  endfunction

  function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                output logic [15:0] r, output logic c, output logic v,
                                output int lat);
    int ux, uy, sx, sy, s;
    ux  = int'(x);
    uy  = int'(y);
    sx  = (ux >= 128) ? ux - 256 : ux;
    sy  = (uy >= 128) ? uy - 256 : uy;
    r   = 16'd0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (o)
      4'd0: begin s = ux + uy; c = (s > 255); v = (sx + sy > 127) || (sx + sy < -128); r = sext8(s % 256); end
      4'd1: begin s = (ux - uy + 256) % 256; c = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); r = sext8(s); end
      4'd2: r = sext8(ux & uy);
      4'd3: r = sext8(ux | uy);
      4'd4: r = sext8(ux ^ uy);
      4'd5: r = sext8(255 - ux);
      4'd6: begin r = sext8((ux * 2) % 256); c = (ux >= 128); end
      4'd7: begin r = sext8(ux / 2); c = (ux % 2 == 1); end
      4'd8: begin s = ux * uy; r = 16'(s); c = (s > 255); lat = 8; end
      4'd9: if (uy == 0) begin r = 16'd255; v = 1'b1; end else begin r = 16'(ux / uy); lat = 8; end
      4'd10: if (uy == 0) begin r = 16'(ux); v = 1'b1; end else begin r = 16'(ux % uy); lat = 8; end
      default: r = 16'd0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input string nm);
    logic [15:0] er;
    logic        ec, ev;
    int          el, cyc;
    model(o, x, y, er, ec, ev, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy cyc=%0d got=%b exp=1", nm, cyc, busy); end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != el) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, cyc, el); end
    checks++;
    if (result !== er) begin failures++; $display("FAIL %s result got=%h exp=%h", nm, result, er); end
    checks++;
    if (carry !== ec) begin failures++; $display("FAIL %s carry got=%b exp=%b", nm, carry, ec); end
    checks++;
    if (overflow !== ev) begin failures++; $display("FAIL %s overflow got=%b exp=%b", nm, overflow, ev); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b exp=0", nm, busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== er) begin
      failures++; $display("FAIL %s hold done=%b result=%h exp done=0 result=%h", nm, done, result, er);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, overflow, carry} !== 20'd0) begin
      failures++; $display("FAIL reset busy=%b done=%b result=%h ovf=%b carry=%b exp all 0", busy, done, result, overflow, carry);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 8'h7F, 8'h01, "add_ovf");
    run_op(OP_SUB, 8'h00, 8'h01, "sub_borrow");
    run_op(OP_MUL, 8'hFF, 8'hFF, "mul_ff");
    run_op(OP_MUL, 8'h03, 8'h04, "mul_small");
    run_op(OP_DIV, 8'd200, 8'd7, "div");
    run_op(OP_MOD, 8'd200, 8'd7, "mod");
    run_op(OP_DIV, 8'h55, 8'h00, "div_zero");
    run_op(OP_MOD, 8'h55, 8'h00, "mod_zero");
    run_op(OP_SHL, 8'h81, 8'h00, "shl");
    run_op(OP_SHR, 8'h01, 8'h00, "shr");
    run_op(4'hF, 8'hA5, 8'h5A, "reserved");
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [7:0] x, y;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      y = 8'($urandom);
      if ((o == 4'd9 || o == 4'd10) && $urandom_range(0, 3) == 0) y = 8'd0;
      run_op(o, x, y, "random");
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      if (done === 1'b1) ndone++;
      if (c == 3) begin
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL ignore_early_done got=%0d exp=0", ndone); end
    checks++;
    if (done !== 1'b1 || result !== 16'hFE01 || carry !== 1'b1) begin
      failures++; $display("FAIL ignore_mul done=%b result=%h carry=%b exp done=1 result=fe01 carry=1", done, result, carry);
    end
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 8'h05; b = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 16'h0008) begin
      failures++; $display("FAIL b2b_add done=%b result=%h exp done=1 result=0008", done, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, overflow, carry} !== 20'd0) begin
      failures++; $display("FAIL rst_mid busy=%b done=%b result=%h ovf=%b carry=%b exp all 0", busy, done, result, overflow, carry);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", ndone); end
    run_op(OP_ADD, 8'h01, 8'h01, "rst_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
